// File: rtl/seq_det_ctrl_if.sv
// Configuration channel of the programmable pattern detector.
// The master offers a pattern set; the slave accepts it with cfg_ready.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [3:0]         cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_thresh;

  modport master (
    output cfg_valid, cfg_pat, cfg_len, cfg_overlap, cfg_thresh,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pat, cfg_len, cfg_overlap, cfg_thresh,
    output cfg_ready
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial Mealy pattern detector with match counting,
// threshold termination and start/stop sequencing.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    cfg,
  input  logic             start,
  input  logic             stop,
  input  logic             d,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state,   w_state_next;
  logic [MAX_LEN-1:0] r_pat,     w_pat_next;
  logic [LEN_W-1:0]   r_len,     w_len_next;
  logic               r_overlap, w_overlap_next;
  logic [CNT_W-1:0]   r_thresh,  w_thresh_next;
  logic [MAX_LEN-2:0] r_hist,    w_hist_next;
  logic [LEN_W-1:0]   r_fill,    w_fill_next;
  logic [CNT_W-1:0]   r_cnt,     w_cnt_next;

  logic [MAX_LEN-1:0] w_window;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_hit;
  logic [LEN_W-1:0]   w_fill_inc;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [LEN_W-1:0]   w_len_clamp;
  logic               w_cfg_ready;

  // Only the low r_len bits of the window take part in the comparison.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign w_mask[gi] = (LEN_W'(gi) < r_len);
    end
  endgenerate

  assign w_window   = {r_hist, d};
  assign w_hit      = (((w_window ^ r_pat) & w_mask) == '0) &&
                      (r_fill >= (r_len - LEN_W'(1)));
  assign w_fill_inc = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
  assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign match_cnt  = r_cnt;
  assign cfg.cfg_ready = w_cfg_ready;

  always_comb begin
    w_len_clamp = LEN_W'(cfg.cfg_len);
    if (int'(cfg.cfg_len) > MAX_LEN) begin
      w_len_clamp = LEN_W'(MAX_LEN);
    end else if (int'(cfg.cfg_len) < 2) begin
      w_len_clamp = LEN_W'(2);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pat_next     = r_pat;
    w_len_next     = r_len;
    w_overlap_next = r_overlap;
    w_thresh_next  = r_thresh;
    w_hist_next    = r_hist;
    w_fill_next    = r_fill;
    w_cnt_next     = r_cnt;
    z              = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    w_cfg_ready    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cfg_ready = 1'b1;
        // A configuration beat takes precedence; start must come later.
        if (cfg.cfg_valid) begin
          w_pat_next     = cfg.cfg_pat;
          w_len_next     = w_len_clamp;
          w_overlap_next = cfg.cfg_overlap;
          w_thresh_next  = cfg.cfg_thresh;
        end else if (start) begin
          w_state_next = S_RUN;
          w_hist_next  = '0;
          w_fill_next  = '0;
          w_cnt_next   = '0;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (stop) begin
          w_state_next = S_IDLE;
        end else begin
          w_hist_next = w_window[MAX_LEN-2:0];
          w_fill_next = w_fill_inc;
          if (w_hit) begin
            z          = 1'b1;
            w_cnt_next = w_cnt_inc;
            if (!r_overlap) begin
              w_fill_next = '0;
            end
            if ((r_thresh != '0) && (w_cnt_inc == r_thresh)) begin
              w_state_next = S_DONE;
            end
          end
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_next = S_RUN;
          w_hist_next  = '0;
          w_fill_next  = '0;
          w_cnt_next   = '0;
        end else if (stop) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pat     <= MAX_LEN'(3'b101);
      r_len     <= LEN_W'(3);
      r_overlap <= 1'b1;
      r_thresh  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pat     <= w_pat_next;
      r_len     <= w_len_next;
      r_overlap <= w_overlap_next;
      r_thresh  <= w_thresh_next;
      r_hist    <= w_hist_next;
      r_fill    <= w_fill_next;
      r_cnt     <= w_cnt_next;
    end
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Run-time programmable controller for the serial Mealy pattern detectors (101/110 family).
- Latches a pattern configuration through a valid/ready handshake and sequences detection on the serial input `d` under start/stop control.
- Counts matches and signals `done` when a programmed threshold is reached.
- Sits between the system control interface and the serial data stream; a single instance replaces the fixed-pattern detectors.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (must be ≥2).
- CNT_W, 8, width of the match counter and threshold.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration offered.
- cfg_ready  output  1  configuration accepted this cycle when high with cfg_valid.
- cfg_pat  input  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  4  pattern length.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cfg_thresh  input  CNT_W  match count that ends the run; 0 = run until stop.
- start  input  1  begin a run (single-cycle pulse).
- stop  input  1  abort a run (single-cycle pulse).
- d  input  1  serial data, sampled every cycle in RUN.
- z  output  1  Mealy match output; combinational, high in the cycle whose `d` completes the pattern.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- match_cnt  output  CNT_W  matches in the current or last run.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - Pattern register = 101, len = 3, overlap = 1, thresh = 0.
  - History and fill counter = 0; match_cnt = 0.
  - z = 0, busy = 0, done = 0, cfg_ready = 1.
  - A reset asserted mid-run aborts immediately; no z is emitted while rst=1.
- States:
  - IDLE: cfg_ready = 1.
    - cfg_valid latches all cfg_* fields at the clock edge.
    - start with cfg_valid low → RUN; clears history, fill and match_cnt.
    - cfg_valid and start in the same cycle: the config is latched and start is ignored; the run needs a later start.
  - RUN: busy = 1, cfg_ready = 0. cfg_valid is ignored and not latched.
  - DONE: done = 1, cfg_ready = 0.
    - start → RUN, with clears as from IDLE.
    - stop → IDLE; match_cnt is held.
- Length rules: cfg_len < 2 is stored as 2; cfg_len > MAX_LEN is stored as MAX_LEN.
- Match condition in RUN:
  - fill ≥ len-1, AND
  - {hist[len-2:0], d} == pat[len-1:0].
  - hist shifts left taking d at each RUN edge.
  - fill saturates at MAX_LEN.
- z = match condition AND state == RUN AND not stop. z is low in IDLE and DONE.
- On a match edge:
  - match_cnt increments, saturating at all-ones.
  - Non-overlap mode: fill resets to 0, so the next match needs len fresh bits.
  - Overlap mode: fill is kept.
- Threshold: when thresh ≠ 0 and the incremented count equals thresh → DONE at that edge. z is still high in the matching cycle.
- stop in RUN → IDLE at the next edge:
  - stop wins over a same-cycle match: z = 0 and no increment.
  - match_cnt holds its value.
- stop in IDLE is ignored. start in RUN is ignored.
- Latency:
  - z is 0 cycles after d (same cycle).
  - match_cnt, done and busy update 1 cycle after the edge.

Test Plan:
- Reset, then start with the default config (101, overlap), and drive d = 1,0,1,1,0,0,1,1,0,1,0,1,0,1 one bit per cycle → z high on bits 3, 10, 12 and 14 (1-based); match_cnt = 4; busy stays 1.
- Configure pat=110, len=3, overlap=1, thresh=0; start; apply the same stream → z on bits 5 and 9; match_cnt = 2.
- Configure pat=101, len=3, overlap=0; same stream → z on bits 3, 10 and 14 only; match_cnt = 3.
- Configure pat=101, len=3, overlap=1, thresh=2; same stream → z on bits 3 and 10; done = 1 from the edge after bit 10; no z afterwards; match_cnt = 2. A start then re-enters RUN with match_cnt = 0.
- Handshake and aborts:
  - cfg_valid during RUN → cfg_ready = 0 and the config is unchanged.
  - stop coincident with a completing bit → z = 0, count unchanged, and IDLE next cycle.
  - rst pulsed mid-run → all outputs at reset values asynchronously, and the config returns to 101/3/overlap.
- Length clamping: cfg_len = 0 with pat = 8'b0000_0011 → behaves as 2-bit pattern "11", so d = 1,1,1 gives z on bits 2 and 3. cfg_len = 15 is treated as 8.
